aes_spi_slave: RTL and testbench
================================

# aes_spi_slave

Serial front end of the AES core, directly downstream of the SPI master on the link. It deserialises command frames from the master (key load, encrypt, decrypt, read result), drives the AES core's key/data/start inputs, captures the core's result on its done strobe, and serialises status and result back on MISO. All SPI pins are oversampled in the system clock domain. There is no second clock.

## Interface
- Parameters: none.
- clk  in  1  system clock; must be ≥ 6× sclk frequency
- rst  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock from master, mode 0, idle low
- cs_n  in  1  chip select, active low
- mosi  in  1  serial data in, MSB first
- miso  out  1  serial data out, MSB first
- nk_val  out  2  key size to core: 00=128, 01=192, 10=256
- key  out  256  key to core, right-aligned, upper bits zero
- data_in  out  128  block to core
- start_enc  out  1  one-cycle encrypt start pulse
- start_dec  out  1  one-cycle decrypt start pulse
- core_done  in  1  one-cycle completion strobe from core
- core_data  in  128  core result, valid while core_done=1
- busy  out  1  core operation outstanding

## Operation
- Frame = cs_n low … cs_n high. First byte is the command: [7:6] op (00 KEY, 01 ENC, 10 DEC, 11 READ), [5:4] nk (KEY only; others ignore), [3:0] zero.
- KEY payload: 16/24/32 bytes for nk 00/01/10, shifted into a staging register.
- ENC/DEC payload: exactly 16 bytes. READ payload: none from master; MOSI is ignored.
- Commit at cs_n rise, only if the exact expected bit count was received:
  - KEY: key ← staging, right-aligned with zero fill; nk_val ← nk.
  - ENC/DEC: data_in ← staging; pulse start_enc or start_dec; busy ← 1.
- Error (sticky until the next READ completes). On error nothing commits and no start pulse is issued. Error conditions:
  - wrong bit count
  - nk=11
  - ENC/DEC or KEY while busy=1
- core_done: result register ← core_data; result_valid ← 1; busy ← 0.
- MISO: at cs_n fall, the shift register loads {status, result}, where status = {busy, result_valid, error, 5'b0}. The shift register advances on each detected sclk fall. For non-READ frames, bits after the status byte are don't-care.
- Complete READ (exactly 17 bytes clocked) clears result_valid and error.
- State machine:
  - IDLE: waits for cs_n fall, then goes to CMD.
  - CMD: 8 bits, then goes to PAYLOAD (or READ).
  - PAYLOAD / READ: counts bits.
  - Any cs_n rise goes to COMMIT (1 cycle), then IDLE.
- 9-bit bit counter saturates at 511. Exceeding the expected length is a count error.

## Timing
- Each of sclk, cs_n and mosi goes through a 2-FF synchronizer and a 1-FF edge detector, giving 3 cycles of pin-to-event latency.
- mosi is sampled on the detected sclk rise, using the delayed copy aligned with sclk.
- miso is valid at most 4 clk cycles after cs_n falls, and at most 4 clk cycles after each sclk fall.
- start_enc/start_dec assert exactly 1 clk cycle after the cs_n-rise event is detected. busy rises in the same cycle.
- core_done and a cs_n rise in the same cycle: the result is captured first. A commit in that cycle sees busy=0.
- cs_n rise mid-byte counts as an error commit; the staging contents are discarded.
- Reset values:
  - miso=0, start_enc=0, start_dec=0, busy=0
  - nk_val=00, key=0, data_in=0
  - result=0, result_valid=0, error=0
  - FSM=IDLE
- Reset mid-frame aborts the frame. The rest of that frame is ignored until cs_n goes high, then low again.

## Configuration
- AES_SPI_CRC8_EN defined: every KEY/ENC/DEC frame carries one trailing CRC-8 byte.
  - Polynomial 0x07, init 0x00, computed over the command byte and the payload.
  - A mismatch is an error and nothing commits.
  - READ frames append the CRC-8 of the status byte and result (18 bytes total).
- Undefined: no CRC byte is sent or expected, and lengths are as above.

## Structure
- Package aes_spi_pkg holds:
  - op codes and nk encodings
  - payload byte counts per op/nk
  - status bit positions
  - CRC polynomial
- One sub-module, aes_spi_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs. It is instantiated three times, for sclk, cs_n and mosi.

## Test plan
- KEY nk=01 with payload 0x000102…1617 (24 bytes) -> key=256'h0…000102030405060708090a0b0c0d0e0f1011121314151617, nk_val=01, error=0.
- ENC with 0x00112233445566778899aabbccddeeff -> one start_enc pulse, data_in matches, busy=1. The core model then returns dda97ca4864cdfe06eaf70a0ec0d7191; READ returns status 0x40 followed by that block. A second READ returns status 0x00.
- DEC with dda97ca4864cdfe06eaf70a0ec0d7191 -> start_dec pulse. Core returns 00112233…eeff; READ returns it.
- ENC frame of 15 bytes -> no start pulse, data_in unchanged, next status 0x20.
- ENC issued while busy -> ignored, error set; the result of the first op is still delivered.
- rst low mid-KEY frame -> all outputs at reset values. The next full frame after cs_n cycles high→low operates normally.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// ============================================================================
// Module   : aes_spi_pkg
// Brief    : Shared encodings, frame lengths and CRC-8 helpers for the AES SPI
//            slave. AES_SPI_CRC8_EN adds a trailing CRC byte to every frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_spi_pkg;

    localparam logic [1:0] OP_KEY  = 2'b00;
    localparam logic [1:0] OP_ENC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam logic [1:0] NK_128 = 2'b00;
    localparam logic [1:0] NK_192 = 2'b01;
    localparam logic [1:0] NK_256 = 2'b10;
    localparam logic [1:0] NK_BAD = 2'b11;

    localparam int KEY_BYTES_128 = 16;
    localparam int KEY_BYTES_192 = 24;
    localparam int KEY_BYTES_256 = 32;
    localparam int BLOCK_BYTES   = 16;

    localparam int STAT_BUSY  = 7;
    localparam int STAT_VALID = 6;
    localparam int STAT_ERROR = 5;

    localparam logic [7:0] CRC_POLY = 8'h07;

`ifdef AES_SPI_CRC8_EN
    localparam int CRC_BITS = 8;
`else
    localparam int CRC_BITS = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_READ    = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    // Total bits of a well-formed frame, command byte and optional CRC included.
    function automatic logic [8:0] frame_bits(input logic [1:0] op, input logic [1:0] nk);
        int bytes;
        bytes = BLOCK_BYTES;
        if (op == OP_KEY) begin
            case (nk)
                NK_128:  bytes = KEY_BYTES_128;
                NK_192:  bytes = KEY_BYTES_192;
                default: bytes = KEY_BYTES_256;
            endcase
        end
        return 9'((1 + bytes) * 8 + CRC_BITS);
    endfunction

    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] crc8_block(input logic [135:0] msg);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = 135; i >= 0; i--) begin
            crc = crc8_bit(crc, msg[i]);
        end
        return crc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_spi_sync_edge.sv
// ============================================================================
// Module   : aes_spi_sync_edge
// Brief    : 2-FF synchronizer with a delay stage producing rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            dly  <= RESET_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~dly;
    assign fall  = ~sync & dly;

endmodule

`default_nettype wire

// File: rtl/aes_spi_slave.sv
// ============================================================================
// Module   : aes_spi_slave
// Brief    : Oversampled SPI mode-0 command front end for the AES core.
//            Define AES_SPI_CRC8_EN to require/append a CRC-8 byte per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_spi_slave
    import aes_spi_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    output logic [1:0]   nk_val,
    output logic [255:0] key,
    output logic [127:0] data_in,
    output logic         start_enc,
    output logic         start_dec,
    input  logic         core_done,
    input  logic [127:0] core_data,
    output logic         busy
);

    localparam int STG_W = 256 + CRC_BITS;
    localparam int TX_W  = 136 + CRC_BITS;

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    aes_spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    // Reset low so a frame already in progress at reset release never yields
    // a fall event; the slave rejoins only on the next genuine cs_n fall.
    aes_spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    aes_spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t             state;
    logic [8:0]         bit_cnt;
    logic [7:0]         cmd;
    logic [STG_W-1:0]   stage;
    logic [TX_W-1:0]    tx;
    logic [127:0]       result;
    logic               result_valid;
    logic               error;

    logic [255:0]       payload;
    logic               crc_ok;
    logic [TX_W-1:0]    tx_load;
    logic [7:0]         status;
    logic               busy_eff;
    logic               count_ok;
    logic [1:0]         cmd_op;
    logic [1:0]         cmd_nk;

    assign cmd_op   = cmd[7:6];
    assign cmd_nk   = cmd[5:4];
    assign busy_eff = busy & ~core_done;
    assign count_ok = (bit_cnt == frame_bits(cmd_op, cmd_nk));
    assign status   = {busy, result_valid, error, 5'b0};
    assign miso     = tx[TX_W-1];

`ifdef AES_SPI_CRC8_EN
    logic [7:0] crc_run;
    // Running the CRC over the received check byte as well leaves zero on a match.
    assign crc_ok  = (crc_run == 8'h00);
    assign payload = stage[STG_W-1:CRC_BITS];
    assign tx_load = {status, result, crc8_block({status, result})};
`else
    assign crc_ok  = 1'b1;
    assign payload = stage;
    assign tx_load = {status, result};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            cmd          <= '0;
            stage        <= '0;
            tx           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b0;
            nk_val       <= NK_128;
            key          <= '0;
            data_in      <= '0;
            start_enc    <= 1'b0;
            start_dec    <= 1'b0;
`ifdef AES_SPI_CRC8_EN
            crc_run      <= '0;
`endif
        end else begin
            start_enc <= 1'b0;
            start_dec <= 1'b0;

            // Result capture precedes any commit in the same cycle.
            if (core_done) begin
                result       <= core_data;
                result_valid <= 1'b1;
                busy         <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                        cmd     <= '0;
                        stage   <= '0;
                        tx      <= tx_load;
`ifdef AES_SPI_CRC8_EN
                        crc_run <= '0;
`endif
                    end
                end

                ST_CMD, ST_PAYLOAD, ST_READ: begin
                    if (cs_rise) begin
                        state <= ST_COMMIT;
                        case (cmd_op)
                            OP_KEY: begin
                                if (!count_ok || cmd_nk == NK_BAD || busy_eff || !crc_ok) begin
                                    error <= 1'b1;
                                end else begin
                                    key    <= payload;
                                    nk_val <= cmd_nk;
                                end
                            end
                            OP_ENC, OP_DEC: begin
                                if (!count_ok || busy_eff || !crc_ok) begin
                                    error <= 1'b1;
                                end else begin
                                    data_in   <= payload[127:0];
                                    busy      <= 1'b1;
                                    start_enc <= (cmd_op == OP_ENC);
                                    start_dec <= (cmd_op == OP_DEC);
                                end
                            end
                            default: begin
                                if (count_ok) begin
                                    error <= 1'b0;
                                    if (!core_done) result_valid <= 1'b0;
                                end else begin
                                    error <= 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        if (sclk_rise) begin
                            if (bit_cnt != 9'h1FF) bit_cnt <= bit_cnt + 9'd1;
`ifdef AES_SPI_CRC8_EN
                            crc_run <= crc8_bit(crc_run, mosi_s);
`endif
                            if (state == ST_CMD) begin
                                cmd <= {cmd[6:0], mosi_s};
                                if (bit_cnt == 9'd7) begin
                                    state <= (cmd[6:5] == OP_READ) ? ST_READ : ST_PAYLOAD;
                                end
                            end else if (state == ST_PAYLOAD) begin
                                stage <= {stage[STG_W-2:0], mosi_s};
                            end
                        end
                        if (sclk_fall) tx <= {tx[TX_W-2:0], 1'b0};
                    end
                end

                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_spi_slave.sv
// ============================================================================
// Module   : tb_aes_spi_slave
// Brief    : Directed self-checking bench for aes_spi_slave (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_spi_slave;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic         miso;
    logic [1:0]   nk_val;
    logic [255:0] key;
    logic [127:0] data_in;
    logic         start_enc;
    logic         start_dec;
    logic         core_done = 1'b0;
    logic [127:0] core_data = '0;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    int enc_cnt = 0;
    int dec_cnt = 0;

    logic [7:0] txb [0:33];
    logic [7:0] rxb [0:33];

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] BLK_A = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] BLK_B = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] RES_X = 128'hcafebabe0123456789abcdefdeadbeef;

    aes_spi_slave dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .nk_val(nk_val), .key(key), .data_in(data_in),
        .start_enc(start_enc), .start_dec(start_dec),
        .core_done(core_done), .core_data(core_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start_enc) enc_cnt <= enc_cnt + 1;
        if (start_dec) dec_cnt <= dec_cnt + 1;
    end

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        for (int k = 7; k >= 0; k--) begin
            mosi = b[k];
            #60;
            r[k] = miso;
            sclk = 1'b1;
            #60;
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic frame(input int n);
        cs_n = 1'b0;
        #100;
        for (int i = 0; i < n; i++) spi_byte(txb[i], rxb[i]);
        #60;
        cs_n = 1'b1;
        #200;
    endtask

    task automatic clear_tx();
        for (int i = 0; i < 34; i++) txb[i] = 8'h00;
    endtask

    task automatic block_frame(input logic [7:0] c, input logic [127:0] d, input int nbytes);
        clear_tx();
        txb[0] = c;
        for (int i = 0; i < 16; i++) txb[1 + i] = d[127 - 8 * i -: 8];
        frame(nbytes + 1);
    endtask

    task automatic do_read(output logic [7:0] st, output logic [127:0] res);
        clear_tx();
        txb[0] = 8'hC0;
        frame(17);
        st  = rxb[0];
        res = '0;
        for (int i = 1; i <= 16; i++) res = {res[119:0], rxb[i]};
    endtask

    task automatic core_respond(input logic [127:0] d);
        @(negedge clk);
        core_data = d;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        #50;
    endtask

    logic [7:0]   st;
    logic [127:0] res;
    logic [7:0]   junk;

    initial begin
        #23;
        chk("rst_miso", {255'b0, miso}, 256'd0);
        chk("rst_busy", {255'b0, busy}, 256'd0);
        chk("rst_key", key, 256'd0);
        chk("rst_nk", {254'b0, nk_val}, 256'd0);
        chk("rst_data", {128'b0, data_in}, 256'd0);
        rst = 1'b1;
        #100;

        // KEY nk=01, 24 bytes 00..17
        clear_tx();
        txb[0] = 8'h10;
        for (int i = 0; i < 24; i++) txb[1 + i] = 8'(i);
        frame(25);
        chk("key192", key, 256'h000102030405060708090a0b0c0d0e0f1011121314151617);
        chk("key192_nk", {254'b0, nk_val}, 256'd1);
        do_read(st, res);
        chk("key192_status", {248'b0, st}, 256'h00);

        // ENC, core result, two READs
        block_frame(8'h40, PT, 16);
        chk("enc_data", {128'b0, data_in}, {128'b0, PT});
        chk("enc_pulses", 256'(enc_cnt), 256'd1);
        chk("enc_busy", {255'b0, busy}, 256'd1);
        do_read(st, res);
        chk("busy_status", {248'b0, st}, 256'h80);
        core_respond(CT);
        chk("enc_done_busy", {255'b0, busy}, 256'd0);
        do_read(st, res);
        chk("enc_read_status", {248'b0, st}, 256'h40);
        chk("enc_read_result", {128'b0, res}, {128'b0, CT});
        do_read(st, res);
        chk("second_read_status", {248'b0, st}, 256'h00);

        // DEC
        block_frame(8'h80, CT, 16);
        chk("dec_pulses", 256'(dec_cnt), 256'd1);
        chk("dec_data", {128'b0, data_in}, {128'b0, CT});
        core_respond(PT);
        do_read(st, res);
        chk("dec_read_status", {248'b0, st}, 256'h40);
        chk("dec_read_result", {128'b0, res}, {128'b0, PT});

        // Short ENC frame (15 payload bytes)
        block_frame(8'h40, BLK_A, 15);
        chk("short_pulses", 256'(enc_cnt), 256'd1);
        chk("short_data", {128'b0, data_in}, {128'b0, CT});
        do_read(st, res);
        chk("short_status", {248'b0, st}, 256'h20);
        do_read(st, res);
        chk("short_cleared", {248'b0, st}, 256'h00);

        // ENC while busy
        block_frame(8'h40, BLK_A, 16);
        block_frame(8'h40, BLK_B, 16);
        chk("busy_pulses", 256'(enc_cnt), 256'd2);
        chk("busy_data", {128'b0, data_in}, {128'b0, BLK_A});
        core_respond(RES_X);
        do_read(st, res);
        chk("busy_read_status", {248'b0, st}, 256'h60);
        chk("busy_read_result", {128'b0, res}, {128'b0, RES_X});

        // KEY with nk=11 is rejected
        clear_tx();
        txb[0] = 8'h30;
        for (int i = 0; i < 32; i++) txb[1 + i] = 8'hA5;
        frame(33);
        chk("nkbad_key", key, 256'h000102030405060708090a0b0c0d0e0f1011121314151617);
        do_read(st, res);
        chk("nkbad_status", {248'b0, st}, 256'h20);

        // Reset in the middle of a KEY frame
        cs_n = 1'b0;
        #100;
        spi_byte(8'h20, junk);
        for (int i = 0; i < 4; i++) spi_byte(8'h55, junk);
        rst = 1'b0;
        #30;
        chk("midrst_key", key, 256'd0);
        chk("midrst_nk", {254'b0, nk_val}, 256'd0);
        chk("midrst_data", {128'b0, data_in}, 256'd0);
        chk("midrst_busy_miso", {254'b0, busy, miso}, 256'd0);
        rst = 1'b1;
        #20;
        for (int i = 0; i < 28; i++) spi_byte(8'h55, junk);
        #60;
        cs_n = 1'b1;
        #200;
        chk("midrst_key_after", key, 256'd0);
        do_read(st, res);
        chk("midrst_status", {248'b0, st}, 256'h00);
        chk("midrst_result", {128'b0, res}, 256'd0);

        clear_tx();
        txb[0] = 8'h20;
        for (int i = 0; i < 32; i++) txb[1 + i] = 8'(8'h20 + i);
        frame(33);
        chk("key256", key, 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);
        chk("key256_nk", {254'b0, nk_val}, 256'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
